cmul_sched: RTL and testbench



---
 rtl/fft_pkg.sv | 12 +
 rtl/cmul_tag_pipe.sv | 25 ++
 rtl/cmul_sched.sv | 95 +++++++++
 tb/tb_cmul_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths, FSM encoding and saturation helper for the FFT datapath
package fft_pkg;
  localparam int DW = 17;
  localparam int TW = 8;
  localparam logic [DW-1:0] SAT_MAX = 17'h0FFFF;
  localparam logic [DW-1:0] SAT_MIN = 17'h10000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  // An 18-bit value fits in 17 bits exactly when its top two bits agree
  function automatic logic [DW-1:0] sat18(input logic [DW:0] v);
    return (v[DW] == v[DW-1]) ? v[DW-1:0] : (v[DW] ? SAT_MIN : SAT_MAX);
  endfunction
endpackage

// File: rtl/cmul_tag_pipe.sv
// cmul_tag_pipe: LAT-deep {valid, k} shift register tracking products in flight
module cmul_tag_pipe #(
  parameter int LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_v,
  input  logic [1:0] in_k,
  output logic       out_v,
  output logic [1:0] out_k
);
  logic [LAT-1:0]      v;
  logic [LAT-1:0][1:0] k;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      k <= '0;
    end else begin
      v <= {v[LAT-2:0], in_v};
      k <= {k[LAT-2:0], in_k};
    end
  end
  assign out_v = v[LAT-1];
  assign out_k = k[LAT-1];
endmodule

// File: rtl/cmul_sched.sv
// cmul_sched: complex twiddle multiply over one shared pipelined real multiplier
module cmul_sched
  import fft_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_xr,
  input  logic [DW-1:0] in_xi,
  input  logic [TW-1:0] in_wr,
  input  logic [TW-1:0] in_wi,
  input  logic          in_conj,
  output logic [DW-1:0] mul_a,
  output logic [TW-1:0] mul_b,
  input  logic [DW-1:0] mul_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          busy
);
  state_t state, nxt;
  logic [1:0] cnt, hk;
  logic hv, conj, fin;
  logic [DW-1:0] xr, xi;
  logic [TW-1:0] wr, wi;
  logic signed [DW:0] acc_re, acc_im, p, re_nxt, im_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = ISSUE;
      ISSUE:   if (cnt == 2'd3) nxt = WAIT;
      WAIT:    if (fin) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Issue order k0..k3: xr*wr, xi*wi, xr*wi, xi*wr
  always_comb begin
    in_ready  = rst_n && state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    mul_a     = state == ISSUE ? (cnt[0] ? xi : xr) : '0;
    mul_b     = state == ISSUE ? ((cnt[0] ^ cnt[1]) ? wi : wr) : '0;
  end

  cmul_tag_pipe #(.LAT(MUL_LAT)) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (state == ISSUE),
    .in_k  (cnt),
    .out_v (hv),
    .out_k (hk)
  );

  // k0/k1 feed the real part, k2/k3 the imaginary part; conj flips which term subtracts
  always_comb begin
    p      = {mul_p[DW-1], mul_p};
    re_nxt = acc_re + ((hv && !hk[1]) ? ((hk[0] && !conj) ? -p : p) : '0);
    im_nxt = acc_im + ((hv && hk[1]) ? ((!hk[0] && conj) ? -p : p) : '0);
    fin    = hv && hk == 2'd3 && state == WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {xr, xi, wr, wi, conj} <= '0;
      {acc_re, acc_im}       <= '0;
      {out_re, out_im}       <= '0;
      cnt                    <= '0;
    end else begin
      if (in_valid && in_ready) begin
        {xr, xi, wr, wi, conj} <= {in_xr, in_xi, in_wr, in_wi, in_conj};
        {acc_re, acc_im}       <= '0;
      end else begin
        acc_re <= re_nxt;
        acc_im <= im_nxt;
      end
      cnt <= state == ISSUE ? cnt + 2'd1 : '0;
      if (fin) begin
        out_re <= sat18(re_nxt);
        out_im <= sat18(im_nxt);
      end
    end
  end
endmodule

// File: tb/tb_cmul_sched.sv
// tb_cmul_sched: directed checks of cmul_sched with a behavioural shared multiplier
module tb_cmul_sched;
  import fft_pkg::*;
  logic clk = 0, rst_n = 1, in_valid = 0, in_conj = 0, out_ready = 1;
  logic [DW-1:0] in_xr = '0, in_xi = '0, mul_a, mul_p, out_re, out_im;
  logic [TW-1:0] in_wr = '0, in_wi = '0, mul_b;
  logic in_ready, out_valid, busy;
  logic [DW-1:0] mp [4] = '{default: '0};
  logic [DW-1:0] sa [4];
  logic [TW-1:0] sb [4];
  int tests = 0, fails = 0, cyc = 0;

  cmul_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_xr(in_xr), .in_xi(in_xi), .in_wr(in_wr), .in_wi(in_wi), .in_conj(in_conj),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mulf(input logic [DW-1:0] a, input logic [TW-1:0] b);
    logic [DW-1:0] ma;
    logic [TW-1:0] mb;
    logic [DW+TW-1:0] m;
    ma = a[DW-1] ? -a : a;
    mb = b[TW-1] ? -b : b;
    m  = ({{TW{1'b0}}, ma} * {{DW{1'b0}}, mb}) >> 6;
    return (a[DW-1] ^ b[TW-1]) ? -m[DW-1:0] : m[DW-1:0];
  endfunction

  always @(posedge clk) begin
    mp[0] <= mulf(mul_a, mul_b);
    for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[3];

  task automatic gold(input logic [DW-1:0] xr, xi, input logic [TW-1:0] wr, wi,
                      input logic cj, output logic [DW-1:0] er, ei);
    int p0, p1, p2, p3, r, m;
    p0 = $signed(mulf(xr, wr));
    p1 = $signed(mulf(xi, wi));
    p2 = $signed(mulf(xr, wi));
    p3 = $signed(mulf(xi, wr));
    r = cj ? p0 + p1 : p0 - p1;
    m = cj ? p3 - p2 : p2 + p3;
    er = r > 65535 ? 17'h0FFFF : r < -65536 ? 17'h10000 : r[DW-1:0];
    ei = m > 65535 ? 17'h0FFFF : m < -65536 ? 17'h10000 : m[DW-1:0];
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [DW-1:0] xr, xi, input logic [TW-1:0] wr, wi,
                        input logic cj, input logic [DW-1:0] er, ei, input string nm);
    int lat;
    {in_xr, in_xi, in_wr, in_wi, in_conj} = {xr, xi, wr, wi, cj};
    in_valid = 1;
    step;
    in_valid = 0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i <= 4) begin
        sa[i-1] = mul_a;
        sb[i-1] = mul_b;
      end
      if (out_valid) begin
        lat = i;
        break;
      end
      step;
    end
    tests++;
    if (lat != 9) begin
      fails++;
      $display("FAIL %s latency: got %0d exp 9", nm, lat);
    end
    tests++;
    if (out_re !== er || out_im !== ei) begin
      fails++;
      $display("FAIL %s result: got %h/%h exp %h/%h", nm, out_re, out_im, er, ei);
    end
    step;
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, mul_a, mul_b, out_re, out_im} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got rdy=%b v=%b busy=%b a=%h b=%h re=%h im=%h exp all 0",
               in_ready, out_valid, busy, mul_a, mul_b, out_re, out_im);
    end
    step;
    step;
    rst_n = 1;
    step;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset idle: got rdy=%b busy=%b exp 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    run_op(17'h00100, 17'h0, 8'h40, 8'h0, 1'b0, 17'h00100, 17'h0, "basic");
    tests++;
    if ({sa[0], sb[0], sa[1], sb[1], sa[2], sb[2], sa[3], sb[3]} !==
        {17'h100, 8'h40, 17'h0, 8'h0, 17'h100, 8'h0, 17'h0, 8'h40}) begin
      fails++;
      $display("FAIL basic issue seq: got %h/%h %h/%h %h/%h %h/%h exp 100/40 0/0 100/0 0/40",
               sa[0], sb[0], sa[1], sb[1], sa[2], sb[2], sa[3], sb[3]);
    end
    tests++;
    if (mul_a !== '0 || mul_b !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic idle mul: got a=%h b=%h busy=%b exp 0/0/0", mul_a, mul_b, busy);
    end
  endtask

  task automatic test_conj;
    run_op(17'h0, 17'h00100, 8'h0, 8'h40, 1'b0, 17'h1FF00, 17'h0, "imag_noconj");
    run_op(17'h0, 17'h00100, 8'h0, 8'h40, 1'b1, 17'h00100, 17'h0, "imag_conj");
  endtask

  task automatic test_sat;
    run_op(17'h0FFFF, 17'h10001, 8'h40, 8'h40, 1'b0, 17'h0FFFF, 17'h0, "sat_pos");
    run_op(17'h10001, 17'h0FFFF, 8'h40, 8'h40, 1'b0, 17'h10000, 17'h0, "sat_neg");
  endtask

  task automatic test_backpressure;
    int got;
    out_ready = 0;
    {in_xr, in_xi, in_wr, in_wi, in_conj} = {17'h01234, 17'h00567, 8'h40, 8'h00, 1'b0};
    in_valid = 1;
    step;
    in_valid = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (out_valid) got = 1;
      else step;
    end
    tests++;
    if (!got || out_re !== 17'h01234 || out_im !== 17'h00567) begin
      fails++;
      $display("FAIL bp result: got v=%b %h/%h exp 1 01234/00567", out_valid, out_re, out_im);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_xr = 17'h00777;
      step;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_re !== 17'h01234 || out_im !== 17'h00567) begin
        fails++;
        $display("FAIL bp hold cyc %0d: got v=%b rdy=%b %h/%h exp 1/0 01234/00567",
                 i, out_valid, in_ready, out_re, out_im);
      end
    end
    in_valid = 0;
    out_ready = 1;
    step;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp release: got v=%b rdy=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid;
    {in_xr, in_xi, in_wr, in_wi, in_conj} = {17'h0ABCD, 17'h01357, 8'h40, 8'h20, 1'b0};
    in_valid = 1;
    step;
    in_valid = 0;
    step;
    step;
    step;
    rst_n = 0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, mul_a, mul_b, out_re, out_im} !== '0) begin
      fails++;
      $display("FAIL midreset outputs: got rdy=%b v=%b busy=%b a=%h b=%h re=%h im=%h exp all 0",
               in_ready, out_valid, busy, mul_a, mul_b, out_re, out_im);
    end
    step;
    rst_n = 1;
    run_op(17'h00100, 17'h0, 8'h40, 8'h0, 1'b0, 17'h00100, 17'h0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] er, ei;
    int prev, acc, got;
    prev = -1;
    out_ready = 1;
    in_valid = 1;
    for (int n = 0; n < 8; n++) begin
      in_xr = DW'($urandom);
      in_xi = DW'($urandom);
      in_wr = TW'($urandom);
      in_wi = TW'($urandom);
      in_conj = 1'($urandom);
      gold(in_xr, in_xi, in_wr, in_wi, in_conj, er, ei);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        if (in_ready) got = 1;
        else step;
      end
      acc = cyc;
      if (n > 0) begin
        tests++;
        if (!got || acc - prev != 10) begin
          fails++;
          $display("FAIL b2b interval %0d: got %0d exp 10", n, acc - prev);
        end
      end
      prev = acc;
      step;
      got = 0;
      for (int i = 0; i < 30 && !got; i++) begin
        if (out_valid) got = 1;
        else step;
      end
      tests++;
      if (!got || out_re !== er || out_im !== ei) begin
        fails++;
        $display("FAIL b2b result %0d: got v=%b %h/%h exp %h/%h", n, out_valid, out_re, out_im, er, ei);
      end
    end
    in_valid = 0;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_conj;
    test_sat;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
